uart_tx_queue: RTL and testbench

Parametrised UART transmit subsystem: a write-side FIFO feeding an integrated serialiser. It replaces the externally-indexed send queue plus separate sender pair. Producers push words with a valid/full handshake. The block drains the FIFO onto UART_TX with configurable baud divisor, data width, parity and stop bits, and has back-to-back framing and overflow reporting. It sits between core I/O write logic and the board TX pin.

---
 rtl/uart_tx_queue.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: write-side FIFO feeding an integrated UART serialiser.
//
// Producers push words with wr_en and observe full/empty/count. The
// serialiser pops whenever it is idle or at the last cycle of the last stop
// bit, so queued words go out back to back with no idle gap between frames.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   wr_en        push request (ignored while full)
//   wr_data      word to push
//   full         FIFO holds DEPTH words
//   empty        FIFO holds 0 words
//   count        current occupancy
//   overflow     sticky: push attempted while full
//   clr_overflow clears overflow (a simultaneous set wins)
//   busy         a frame is in progress
//   UART_TX      registered serial line, idle high
module uart_tx_queue #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 512,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_overflow,
   output logic                     busy,
   output logic                     UART_TX
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DataLast = 4'(DATA_W - 1);
   localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   CountMax = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic              overflow_q;

   state_e            state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;

   logic              full_int, empty_int;
   logic              push, pop, baud_last;
   logic [DATA_W-1:0] rd_word;

   assign full_int  = (count_q == CountMax);
   assign empty_int = (count_q == '0);
   assign baud_last = (baud_q == BaudLast);
   assign rd_word   = mem[rd_ptr_q];
   assign push      = wr_en && !full_int;
   assign pop       = !empty_int &&
                      ((state_q == StIdle) ||
                       ((state_q == StStop) && baud_last && (bit_q == StopLast)));

   // FIFO storage carries no reset; only the pointers define valid contents.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + (AW + 1)'(1);
         end else if (!push && pop) begin
            count_q <= count_q - (AW + 1)'(1);
         end
         if (wr_en && full_int) begin
            overflow_q <= 1'b1;
         end else if (clr_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // Serialiser state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic; tx_d is the value the line takes after this edge.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;

      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            baud_d = '0;
         end
         StStart: begin
            if (baud_last) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (baud_last) begin
               if (bit_q == DataLast) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     tx_d    = par_q;
                     state_d = StPar;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StStop;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         StPar: begin
            if (baud_last) begin
               tx_d    = 1'b1;
               bit_d   = '0;
               state_d = StStop;
            end
         end
         StStop: begin
            if (baud_last) begin
               if (bit_q == StopLast) begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase

      // A pop overrides the above: load the word and open the start bit.
      if (pop) begin
         state_d = StStart;
         tx_d    = 1'b0;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = rd_word;
         par_d   = (PARITY == 1) ? ~(^rd_word) : ^rd_word;
      end
   end

   // Outputs.
   always_comb begin
      busy     = (state_q != StIdle);
      full     = full_int;
      empty    = empty_int;
      count    = count_q;
      overflow = overflow_q;
      UART_TX  = tx_q;
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue. Instance a: DEPTH=4, no parity, 1 stop.
// Instances b/c share stimulus: b is even parity + 2 stops, c odd parity.
module tb_uart_tx_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, wr_en_a, clr_a;
   logic [7:0] wd_a;
   logic       full_a, empty_a, ovf_a, busy_a, tx_a;
   logic [2:0] count_a;

   logic       rst_bc, wr_en_bc, clr_bc;
   logic [7:0] wd_bc;
   logic       full_b, empty_b, ovf_b, busy_b, tx_b;
   logic       full_c, empty_c, ovf_c, busy_c, tx_c;
   logic [2:0] count_b, count_c;

   int n_checks = 0;
   int n_pass   = 0;
   int gaps     = 0;

   uart_tx_queue #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut_a (
      .CLK(clk), .RST_N(rst_a), .wr_en(wr_en_a), .wr_data(wd_a), .full(full_a),
      .empty(empty_a), .count(count_a), .overflow(ovf_a), .clr_overflow(clr_a),
      .busy(busy_a), .UART_TX(tx_a)
   );

   uart_tx_queue #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut_b (
      .CLK(clk), .RST_N(rst_bc), .wr_en(wr_en_bc), .wr_data(wd_bc), .full(full_b),
      .empty(empty_b), .count(count_b), .overflow(ovf_b), .clr_overflow(clr_bc),
      .busy(busy_b), .UART_TX(tx_b)
   );

   uart_tx_queue #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_c (
      .CLK(clk), .RST_N(rst_bc), .wr_en(wr_en_bc), .wr_data(wd_bc), .full(full_c),
      .empty(empty_c), .count(count_c), .overflow(ovf_c), .clr_overflow(clr_bc),
      .busy(busy_c), .UART_TX(tx_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at the first sample where the start bit should be visible; checks
   // each bit mid-period and counts samples where busy dropped.
   task automatic frame_a(input logic [7:0] w, input string tag);
      for (int j = 0; j < 40; j++) begin
         if (j % 4 == 1) begin
            int   b;
            logic e;
            b = j / 4;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[b-1];
            check(tag, 32'(tx_a), 32'(e));
         end
         if (!busy_a) gaps++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_a = 1'b0; wr_en_a = 1'b0; clr_a = 1'b0; wd_a = 8'h00;
      rst_bc = 1'b0; wr_en_bc = 1'b0; clr_bc = 1'b0; wd_bc = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_full", 32'(full_a), 32'd0);
      check("rst_empty", 32'(empty_a), 32'd1);
      check("rst_count", 32'(count_a), 32'd0);
      check("rst_ovf", 32'(ovf_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      rst_a = 1'b1; rst_bc = 1'b1;
      @(negedge clk);

      // Single 0x55 frame.
      wr_en_a = 1'b1; wd_a = 8'h55;
      @(negedge clk);
      wr_en_a = 1'b0;
      check("t1_count_acc", 32'(count_a), 32'd1);
      check("t1_tx_idle", 32'(tx_a), 32'd1);
      check("t1_busy_pre", 32'(busy_a), 32'd0);
      @(negedge clk);
      check("t1_tx_start", 32'(tx_a), 32'd0);
      check("t1_busy_on", 32'(busy_a), 32'd1);
      check("t1_empty_pop", 32'(empty_a), 32'd1);
      gaps = 0;
      frame_a(8'h55, "t1_bit");
      check("t1_busy_gaps", 32'(gaps), 32'd0);
      check("t1_busy_off", 32'(busy_a), 32'd0);
      check("t1_tx_end", 32'(tx_a), 32'd1);
      repeat (3) @(negedge clk);

      // Back-to-back frames; the second push coincides with the first pop.
      fork
         begin
            wr_en_a = 1'b1; wd_a = 8'hA0;
            @(negedge clk);
            check("t3_count1", 32'(count_a), 32'd1);
            wd_a = 8'h0F;
            @(negedge clk);
            check("t5_push_pop", 32'(count_a), 32'd1);
            wd_a = 8'hFF;
            @(negedge clk);
            wr_en_a = 1'b0;
            check("t3_count2", 32'(count_a), 32'd2);
         end
         begin
            repeat (2) @(negedge clk);
            gaps = 0;
            frame_a(8'hA0, "t3_a0");
            frame_a(8'h0F, "t3_0f");
            frame_a(8'hFF, "t3_ff");
         end
      join
      check("t3_busy_gaps", 32'(gaps), 32'd0);
      check("t3_busy_off", 32'(busy_a), 32'd0);
      check("t3_empty", 32'(empty_a), 32'd1);
      repeat (3) @(negedge clk);

      // Overflow while a frame holds the FSM off.
      fork
         begin
            wr_en_a = 1'b1; wd_a = 8'h11;
            @(negedge clk);
            wr_en_a = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
               wr_en_a = 1'b1; wd_a = 8'h21 + 8'(i);
               @(negedge clk);
            end
            wr_en_a = 1'b0;
            check("t2_count", 32'(count_a), 32'd4);
            check("t2_full", 32'(full_a), 32'd1);
            check("t2_ovf_set", 32'(ovf_a), 32'd1);
            clr_a = 1'b1;
            @(negedge clk);
            clr_a = 1'b0;
            check("t2_ovf_clr", 32'(ovf_a), 32'd0);
            clr_a = 1'b1; wr_en_a = 1'b1; wd_a = 8'h26;
            @(negedge clk);
            clr_a = 1'b0; wr_en_a = 1'b0;
            check("t2_set_wins", 32'(ovf_a), 32'd1);
            check("t2_count_held", 32'(count_a), 32'd4);
            clr_a = 1'b1;
            @(negedge clk);
            clr_a = 1'b0;
         end
         begin
            repeat (2) @(negedge clk);
            gaps = 0;
            frame_a(8'h11, "t2_11");
            frame_a(8'h21, "t2_21");
            frame_a(8'h22, "t2_22");
            frame_a(8'h23, "t2_23");
            frame_a(8'h24, "t2_24");
         end
      join
      check("t2_busy_gaps", 32'(gaps), 32'd0);
      check("t2_no_5th", 32'(busy_a), 32'd0);
      check("t2_empty", 32'(empty_a), 32'd1);
      repeat (3) @(negedge clk);

      // Reset mid-DATA with three words queued.
      for (int i = 0; i < 4; i++) begin
         wr_en_a = 1'b1; wd_a = 8'h31 + 8'(i);
         @(negedge clk);
      end
      wr_en_a = 1'b0;
      check("t6_queued", 32'(count_a), 32'd3);
      repeat (8) @(negedge clk);
      // Data bit 1 of 0x31 is on the line here.
      check("t6_tx_low_pre", 32'(tx_a), 32'd0);
      #2 rst_a = 1'b0;
      #1;
      check("t6_tx_high", 32'(tx_a), 32'd1);
      check("t6_count0", 32'(count_a), 32'd0);
      check("t6_empty", 32'(empty_a), 32'd1);
      check("t6_busy0", 32'(busy_a), 32'd0);
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      wr_en_a = 1'b1; wd_a = 8'h3C;
      @(negedge clk);
      wr_en_a = 1'b0;
      @(negedge clk);
      gaps = 0;
      frame_a(8'h3C, "t6_new");
      check("t6_busy_gaps", 32'(gaps), 32'd0);
      check("t6_only_new", 32'(busy_a), 32'd0);
      check("t6_empty_end", 32'(empty_a), 32'd1);

      // Parity and stop-bit variants on 0x07.
      begin
         int nb, nc;
         logic [7:0] w;
         nb = 0; nc = 0; w = 8'h07;
         wr_en_bc = 1'b1; wd_bc = w;
         @(negedge clk);
         wr_en_bc = 1'b0;
         @(negedge clk);
         for (int j = 0; j < 52; j++) begin
            if (j % 4 == 1) begin
               int   b;
               logic eb, ec;
               b  = j / 4;
               eb = (b == 0) ? 1'b0 : (b <= 8) ? w[b-1] : (b == 9) ? 1'b1 : 1'b1;
               ec = (b == 0) ? 1'b0 : (b <= 8) ? w[b-1] : (b == 9) ? 1'b0 : 1'b1;
               if (b < 12) check("t4_even_bit", 32'(tx_b), 32'(eb));
               if (b < 11) check("t4_odd_bit", 32'(tx_c), 32'(ec));
            end
            if (busy_b) nb++;
            if (busy_c) nc++;
            @(negedge clk);
         end
         check("t4_len_even_2stop", 32'(nb), 32'd48);
         check("t4_len_odd_1stop", 32'(nc), 32'd44);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
